// File: rtl/repopulation.sv
// Breeding stage: rebuilds a population from elite parents plus LFSR-driven crossover.
// Optional mutation of crossed children is enabled by defining REPOP_MUTATION_EN.
module repopulation #(
    parameter int          IND_W     = 300,
    parameter int          NUM_SEL   = 5,
    parameter int          NUM_POP   = 25,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_SEL*IND_W-1:0]   sel_pop,
    output logic [NUM_POP*IND_W-1:0]   pop,
    output logic                       busy,
    output logic                       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BREED = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int KW = (NUM_POP > 1) ? $clog2(NUM_POP) : 1;
    localparam int SW = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NUM_POP - 1);
    localparam logic [SW-1:0] A_LAST = SW'(NUM_SEL - 1);
    localparam logic [SW:0]   NSEL   = (SW+1)'(NUM_SEL);
    localparam logic [9:0]    IW     = 10'(IND_W);

    logic [1:0]               state;
    logic [KW-1:0]            k;
    logic [SW-1:0]            a;
    logic [SW-1:0]            r;
    logic [15:0]              lfsr;
    logic [15:0]              lfsr_nxt;
    logic [NUM_SEL*IND_W-1:0] par;

    logic [SW:0]              sum;
    logic [SW-1:0]            b;
    logic [9:0]               p;
    logic [IND_W-1:0]         pa;
    logic [IND_W-1:0]         pb;
    logic [IND_W-1:0]         child;
`ifdef REPOP_MUTATION_EN
    localparam logic [9:0]    HALF = 10'(IND_W / 2);
    logic [9:0]               m;
`endif

    always_comb begin
        lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

        sum = {1'b0, a} + {1'b0, r};
        if (sum >= NSEL) begin
            sum = sum - NSEL;
        end
        b = sum[SW-1:0];

        // Folding 9 LFSR bits once is enough because IND_W >= 256.
        p = {1'b0, lfsr[8:0]};
        if (p >= IW) begin
            p = p - IW;
        end

        pa = par[a*IND_W +: IND_W];
        pb = par[b*IND_W +: IND_W];

        child = '0;
        for (int i = 0; i < IND_W; i++) begin
            child[i] = (10'(i) < p) ? pa[i] : pb[i];
        end
        if (r == '0) begin
            child = pa;
        end

`ifdef REPOP_MUTATION_EN
        m = p + HALF;
        if (m >= IW) begin
            m = m - IW;
        end
        if (r != '0 && lfsr[15:12] == 4'h0) begin
            child[m] = ~child[m];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= '0;
            a     <= '0;
            r     <= '0;
            lfsr  <= LFSR_SEED;
            par   <= '0;
            pop   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_BREED;
                        par   <= sel_pop;
                        k     <= '0;
                        a     <= '0;
                        r     <= '0;
                    end
                end
                S_BREED: begin
                    pop[k*IND_W +: IND_W] <= child;
                    lfsr <= lfsr_nxt;
                    if (a == A_LAST) begin
                        a <= '0;
                        r <= r + 1'b1;
                    end else begin
                        a <= a + 1'b1;
                    end
                    if (k == K_LAST) begin
                        state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
